// File: rtl/cga_pkg.sv
// Shared definitions for the CGA/Tandy VRAM arbiter: FSM encoding, frame-buffer window
// constants and VRAM address width.
package cga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSlot,
    StAccess,
    StDone
  } arb_state_e;

  localparam int unsigned VramAddrW     = 19;
  localparam logic [19:0] FbBaseDefault = 20'hB8000;

  // The CPU window is 32K aligned, so only the top five address bits take part in the decode.
  function automatic logic fb_hit(input logic [19:0] addr, input logic [19:0] base);
    return addr[19:15] == base[19:15];
  endfunction

endpackage

// File: rtl/cga_bus_sync.sv
// Two-flop synchroniser for an asynchronous active-low ISA strobe, plus a one-cycle pulse on
// its synchronised falling edge.
module cga_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_l,
  output logic sync_l,
  output logic fall
);

  // sr_q[1:0] form the synchroniser; sr_q[2] is the previous synced level for edge detect.
  logic [2:0] sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= 3'b111;
    end else begin
      sr_q <= {sr_q[1:0], strobe_l};
    end
  end

  assign sync_l = sr_q[1];
  assign fall   = sr_q[2] & ~sr_q[1];

endmodule

// File: rtl/cga_vram_arbiter.sv
// Arbitrates the single CGA/Tandy VRAM port between ISA CPU cycles and display fetches.
// Optional feature: define CGA_SNOW_EN to emit the snow byte on forced 80-column writes.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter logic [19:0] FB_BASE      = FbBaseDefault,
  parameter int unsigned ADDR_W       = 15,
  parameter bit          USE_BUS_WAIT = 1'b1,
  parameter int unsigned RD_LAT       = 1,
  parameter logic [7:0]  WAIT_MAX     = 8'd63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [19:0]          bus_a,
  input  logic                 bus_memr_l,
  input  logic                 bus_memw_l,
  input  logic [7:0]           bus_d,
  output logic [7:0]           bus_out_mem,
  output logic                 bus_mem_dir,
  output logic                 bus_rdy,
  input  logic                 isa_op_enable,
  input  logic                 vram_read,
  input  logic [VramAddrW-1:0] vid_addr,
  input  logic                 hres_text,
  output logic [VramAddrW-1:0] ram_a,
  output logic                 ram_we_l,
  output logic [7:0]           ram_wd,
  input  logic [7:0]           ram_d,
  output logic                 snow_valid,
  output logic [7:0]           snow_data
);

  localparam logic [1:0] RdLast = 2'(RD_LAT - 1);

  logic memr_sync_l, memr_fall;
  logic memw_sync_l, memw_fall;

  cga_bus_sync u_sync_memr (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_l (bus_memr_l),
    .sync_l   (memr_sync_l),
    .fall     (memr_fall)
  );

  cga_bus_sync u_sync_memw (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_l (bus_memw_l),
    .sync_l   (memw_sync_l),
    .fall     (memw_fall)
  );

  arb_state_e        state_q;
  logic [ADDR_W-1:0] offset_q;
  logic [7:0]        wdata_q;
  logic              is_wr_q;
  logic [7:0]        wait_q;
  logic [1:0]        lat_q;
  logic              bus_rdy_q;

  logic hit, wr_req, rd_req, released, grant;

  // A simultaneous read is ignored when a write falls in the same cycle.
  assign hit      = fb_hit(bus_a, FB_BASE);
  assign wr_req   = hit & memw_fall;
  assign rd_req   = hit & memr_fall & ~memw_fall;
  assign released = is_wr_q ? memw_sync_l : memr_sync_l;
  assign grant    = (isa_op_enable & ~vram_read) | (wait_q == WAIT_MAX);

`ifdef CGA_SNOW_EN
  logic       snow_valid_q;
  logic [7:0] snow_data_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      wait_q      <= '0;
      lat_q       <= '0;
      bus_rdy_q   <= 1'b1;
      ram_we_l    <= 1'b1;
      bus_out_mem <= '0;
      bus_mem_dir <= 1'b0;
`ifdef CGA_SNOW_EN
      snow_valid_q <= 1'b0;
      snow_data_q  <= '0;
`endif
    end else begin
`ifdef CGA_SNOW_EN
      snow_valid_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (wr_req || rd_req) begin
            state_q     <= StWaitSlot;
            offset_q    <= bus_a[ADDR_W-1:0];
            wdata_q     <= bus_d;
            is_wr_q     <= wr_req;
            bus_mem_dir <= ~wr_req;
            bus_rdy_q   <= 1'b0;
            wait_q      <= '0;
          end
        end
        StWaitSlot: begin
          if (released) begin
            state_q     <= StIdle;
            bus_rdy_q   <= 1'b1;
            bus_mem_dir <= 1'b0;
          end else if (grant) begin
            state_q  <= StAccess;
            ram_we_l <= ~is_wr_q;
            lat_q    <= '0;
`ifdef CGA_SNOW_EN
            // With vram_read high a grant can only be the forced one.
            if (is_wr_q && vram_read && hres_text) begin
              snow_valid_q <= 1'b1;
              snow_data_q  <= wdata_q;
            end
`endif
          end else if (wait_q != 8'hFF) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StAccess: begin
          if (is_wr_q) begin
            ram_we_l  <= 1'b1;
            bus_rdy_q <= 1'b1;
            state_q   <= StDone;
          end else if (lat_q == RdLast) begin
            bus_out_mem <= ram_d;
            bus_rdy_q   <= 1'b1;
            state_q     <= StDone;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        StDone: begin
          if (memr_sync_l && memw_sync_l) begin
            state_q     <= StIdle;
            bus_mem_dir <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_a   = (state_q == StAccess) ? VramAddrW'(offset_q) : vid_addr;
  assign ram_wd  = wdata_q;
  assign bus_rdy = USE_BUS_WAIT ? bus_rdy_q : 1'b1;

`ifdef CGA_SNOW_EN
  assign snow_valid = snow_valid_q;
  assign snow_data  = snow_data_q;
`else
  logic unused_hres_text;
  assign unused_hres_text = hres_text;
  assign snow_valid       = 1'b0;
  assign snow_data        = 8'h00;
`endif

endmodule
